// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Holds the 4-bit ALU op-code enum that the decode stage also uses, the op-code
// width, and the state type of the sequential execute FSM.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_start         load i_data / i_shamt / shift kind from i_op
//   i_op            shift op (SLL, SRL or SRA)
//   i_data          value to shift
//   i_shamt         shift amount (nonzero when started)
//   o_next          shift register value after one more step
//   o_last          the coming edge performs the final step
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [ALU_OP_W-1:0] i_op,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [DATA_W-1:0]  o_next,
    output logic               o_last
);

    logic [DATA_W-1:0]  sh_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               left_q;
    logic               arith_q;

    // Single-step shift; SRA replicates the sign bit.
    always_comb begin
        o_next = sh_q;
        if (left_q)
            o_next = {sh_q[DATA_W-2:0], 1'b0};
        else
            o_next = {arith_q & sh_q[DATA_W-1], sh_q[DATA_W-1:1]};
    end

    assign o_last = (cnt_q == SHAMT_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (i_start) begin
            sh_q    <= i_data;
            cnt_q   <= i_shamt;
            left_q  <= (alu_op_e'(i_op) == ALU_SLL);
            arith_q <= (alu_op_e'(i_op) == ALU_SRA);
        end else if (cnt_q != '0) begin
            sh_q  <= o_next;
            cnt_q <= cnt_q - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU execute unit with valid/ready on both sides.
// Arithmetic/logic ops finish in one cycle; shifts step one bit per cycle
// unless ALU_SEQ_FAST_SHIFT_EN is defined, which selects a barrel shifter.
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_valid / o_ready           request handshake
//   i_alu_op, i_operand_a/_b    op code and operands (sampled at accept)
//   o_valid / i_ready           result handshake
//   o_result, o_illegal         registered result, illegal-op flag
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [ALU_OP_W-1:0] i_alu_op,
    input  logic [DATA_W-1:0]   i_operand_a,
    input  logic [DATA_W-1:0]   i_operand_b,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   o_result,
    output logic                o_illegal
);

    alu_state_e        state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              illegal_q, illegal_d;

    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic               op_illegal;
    logic               accept;
    logic               iter_go;
    logic [DATA_W-1:0]  comb_res;

    assign shamt      = i_operand_b[SHAMT_W-1:0];
    assign op_illegal = (i_alu_op > ALU_OP_W'(ALU_SRA));
    assign is_shift   = (i_alu_op == ALU_OP_W'(ALU_SLL)) ||
                        (i_alu_op == ALU_OP_W'(ALU_SRL)) ||
                        (i_alu_op == ALU_OP_W'(ALU_SRA));

    assign o_valid   = (state_q == ST_DONE);
    assign o_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready);
    assign accept    = i_valid && o_ready;
    assign o_result  = result_q;
    assign o_illegal = illegal_q;

    // Single-cycle datapath. Without the barrel shifter, a shift reaching
    // this path has shamt=0, so it simply passes operand A through.
    always_comb begin
        comb_res = '0;
        case (alu_op_e'(i_alu_op))
            ALU_ADD:  comb_res = i_operand_a + i_operand_b;
            ALU_SUB:  comb_res = i_operand_a - i_operand_b;
            ALU_SLT:  comb_res = DATA_W'($signed(i_operand_a) < $signed(i_operand_b));
            ALU_SLTU: comb_res = DATA_W'(i_operand_a < i_operand_b);
            ALU_XOR:  comb_res = i_operand_a ^ i_operand_b;
            ALU_OR:   comb_res = i_operand_a | i_operand_b;
            ALU_AND:  comb_res = i_operand_a & i_operand_b;
`ifdef ALU_SEQ_FAST_SHIFT_EN
            ALU_SLL:  comb_res = i_operand_a << shamt;
            ALU_SRL:  comb_res = i_operand_a >> shamt;
            ALU_SRA:  comb_res = DATA_W'($signed(i_operand_a) >>> shamt);
`else
            ALU_SLL, ALU_SRL, ALU_SRA: comb_res = i_operand_a;
`endif
            default:  comb_res = '0;
        endcase
    end

`ifdef ALU_SEQ_FAST_SHIFT_EN
    assign iter_go = 1'b0;
`else
    logic [DATA_W-1:0] shift_next;
    logic              shift_last;

    assign iter_go = is_shift && (shamt != '0);

    alu_shift_iter #(.DATA_W(DATA_W)) u_shift (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (accept && iter_go),
        .i_op    (i_alu_op),
        .i_data  (i_operand_a),
        .i_shamt (shamt),
        .o_next  (shift_next),
        .o_last  (shift_last)
    );
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        // Drain without a new request returns to IDLE; an accept overrides it.
        if (state_q == ST_DONE && i_ready)
            state_d = ST_IDLE;
        if (accept) begin
            if (iter_go) begin
                state_d = ST_SHIFT;
            end else begin
                state_d   = ST_DONE;
                result_d  = comb_res;
                illegal_d = op_illegal;
            end
        end
`ifndef ALU_SEQ_FAST_SHIFT_EN
        if (state_q == ST_SHIFT && shift_last) begin
            state_d   = ST_DONE;
            result_d  = shift_next;
            illegal_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, out_valid, in_ready, illegal;
    logic [3:0]  op;
    logic [31:0] a, b, res;

    int n_cmp = 0;
    int n_err = 0;
    int lat, nbusy, nvalid;

    always #5 clk = ~clk;

    alu_seq_exec #(.DATA_W(32)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_valid     (in_valid),
        .o_ready     (out_ready),
        .i_alu_op    (op),
        .i_operand_a (a),
        .i_operand_b (b),
        .o_valid     (out_valid),
        .i_ready     (in_ready),
        .o_result    (res),
        .o_illegal   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, then drop i_valid.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // Scramble inputs so a design that resamples them gets caught.
        a = 32'hDEAD_BEEF; b = 32'h1234_5673; op = 4'd0;
    endtask

    // Latency counted from the accept edge (already taken) to o_valid visible.
    task automatic wait_result(output int l, output int busy);
        l = 1; busy = 0;
        while (!out_valid && l < 200) begin
            if (!out_ready) busy++;
            step();
            l++;
        end
    endtask

    function automatic int shift_lat(input int n);
`ifdef ALU_SEQ_FAST_SHIFT_EN
        return 1;
`else
        return n + 1;
`endif
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1;
        op = '0; a = '0; b = '0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", res, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_ready", 32'(out_ready), 32'd1);

        issue(4'd0, 32'd5, 32'd7);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_result", res, 32'd12);
        step();
        check("add_drain", 32'(out_valid), 32'd0);

        // Back-to-back non-shift ops, one result per cycle.
        in_valid = 1'b1; op = 4'd1; a = 32'd0; b = 32'd1;
        step();
        check("sub", res, 32'hFFFF_FFFF);
        op = 4'd2; a = 32'hFFFF_FFFF; b = 32'd1;
        step();
        check("slt", res, 32'd1);
        check("slt_valid", 32'(out_valid), 32'd1);
        op = 4'd3; a = 32'hFFFF_FFFF; b = 32'd1;
        step();
        check("sltu", res, 32'd0);
        op = 4'd4; a = 32'hF0F0_0000; b = 32'h0FF0_00FF;
        step();
        check("xor", res, 32'hFF00_00FF);
        op = 4'd5; a = 32'h0000_1200; b = 32'h0000_0034;
        step();
        check("or", res, 32'h0000_1234);
        op = 4'd6; a = 32'hFF00_FF00; b = 32'h0F0F_0F0F;
        step();
        check("and", res, 32'h0F00_0F00);
        in_valid = 1'b0;
        step();
        check("b2b_drain", 32'(out_valid), 32'd0);

        // Iterative shifts.
        issue(4'd9, 32'h8000_0000, 32'd4);
        wait_result(lat, nbusy);
        check("sra_result", res, 32'hF800_0000);
        check("sra_latency", 32'(lat), 32'(shift_lat(4)));
        check("sra_busy", 32'(nbusy), 32'(shift_lat(4) - 1));
        step();

        issue(4'd7, 32'd1, 32'd0);
        wait_result(lat, nbusy);
        check("sll0_result", res, 32'd1);
        check("sll0_latency", 32'(lat), 32'd1);
        step();

        issue(4'd8, 32'h8000_0000, 32'd31);
        wait_result(lat, nbusy);
        check("srl31_result", res, 32'd1);
        check("srl31_latency", 32'(lat), 32'(shift_lat(31)));
        step();

        issue(4'd7, 32'h0000_00F1, 32'hFFFF_FFE3);  // only low 5 bits (3) count
        wait_result(lat, nbusy);
        check("sll3_result", res, 32'h0000_0788);
        check("sll3_latency", 32'(lat), 32'(shift_lat(3)));
        step();

        issue(4'd9, 32'h4000_0001, 32'd2);
        wait_result(lat, nbusy);
        check("sra_pos", res, 32'h1000_0000);
        step();

        // Backpressure: result frozen, new request held off.
        in_ready = 1'b0;
        issue(4'd0, 32'd100, 32'd23);
        op = 4'd4; a = 32'h0000_00F0; b = 32'h0000_000F; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", res, 32'd123);
            check("bp_ready", 32'(out_ready), 32'd0);
            step();
        end
        in_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(out_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_next_result", res, 32'h0000_00FF);
        check("bp_next_valid", 32'(out_valid), 32'd1);
        step();

        // Illegal op code, then a legal op clears the flag.
        issue(4'd12, 32'd5, 32'd5);
        check("ill_valid", 32'(out_valid), 32'd1);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_result", res, 32'd0);
        issue(4'd0, 32'd1, 32'd1);
        check("ill_clear", 32'(illegal), 32'd0);
        check("ill_next", res, 32'd2);
        step();

        // Reset mid-shift: the pending result must never surface.
        issue(4'd7, 32'd1, 32'd20);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_ready", 32'(out_ready), 32'd1);
        check("rst_mid_result", res, 32'd0);
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid) nvalid++;
        end
        check("rst_no_stale", 32'(nvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Sequential ALU execute unit that consumes the 4-bit ALU operation codes produced by the funct3/funct7 ALU decode stage and returns a result over a valid/ready handshake. Arithmetic and logic ops complete in one cycle. Shifts run iteratively, one bit per cycle, unless the fast-shift build option is enabled. It sits in the execute stage between operand fetch and writeback, and it backpressures the decode side while a shift is in progress.

## Interface
- DATA_W, 32, operand/result width; power of two, ≥8
- SHAMT_W, $clog2(DATA_W), shift-amount width (derived, not overridden)
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready at a clock edge
- i_alu_op  in  4  op code: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9
- i_operand_a  in  DATA_W  first operand / shift source
- i_operand_b  in  DATA_W  second operand; bits [SHAMT_W-1:0] are the shift amount
- o_valid  out  1  result valid
- i_ready  in  1  result consumed when o_valid && i_ready at a clock edge
- o_result  out  DATA_W  result; held stable while o_valid && !i_ready
- o_illegal  out  1  qualifies o_result; set for op codes 10–15

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: o_ready=1. On accept:
  - Non-shift op, illegal op, or shift with shamt=0 → compute, register the result, go to DONE.
  - Shift with shamt≠0 → load the operand and count=shamt, go to SHIFT.
- SHIFT: o_ready=0. Each cycle, shift by 1 (SLL fills zero, SRL fills zero, SRA fills with the sign bit) and decrement count. When count reaches 0, go to DONE.
- DONE: o_valid=1. o_ready=i_ready, so a new request can be accepted in the same cycle the result drains.
  - i_ready without a new accept → IDLE.
  - i_ready with accept → same handling as an accept in IDLE.
  - !i_ready → stay in DONE with o_result and o_illegal frozen.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_W; there is no overflow flag.
  - SLT compares signed, SLTU unsigned. Both return 1 or 0, zero-extended.
- Illegal op (10–15): o_result=0, o_illegal=1, latency 1, FSM behaves as for a non-shift op.
- Operand and op inputs are sampled only at the accept edge. Changes after that edge have no effect on the op in flight.

## Timing
- Reset values: state=IDLE, o_valid=0, o_result=0, o_illegal=0. o_ready=1 in the cycle after reset deasserts.
- Latency is counted in edges from the accept edge, inclusive, to o_valid visible:
  - Non-shift, illegal, or shamt=0: 1.
  - Iterative shift with amount n: n+1.
- Throughput:
  - Back-to-back non-shift ops: one per cycle while i_ready=1.
  - Shifts block new accepts for n cycles.
- Reset asserted in SHIFT or DONE aborts the op. Any pending result is discarded and never presented.
- i_valid while o_ready=0 is ignored. The requester must hold it (the standard valid/ready rule).

## Configuration
- Macro ALU_SEQ_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter, the SHIFT state and counter are not built, and all ops have latency 1.
- Undefined (default): iterative shifter as described above.
- Results are bit-identical in both builds. Only latency and o_ready timing differ.

## Structure
- Shared package alu_pkg holds:
  - the alu_op_e enum with the op-code constants above, shared with the ALU decode stage;
  - an ALU_OP_W=4 constant;
  - the FSM state typedef.
- Sub-module alu_shift_iter holds the shift register, count, and done flag. It is instantiated only when ALU_SEQ_FAST_SHIFT_EN is undefined.
- The top level holds the FSM, the single-cycle datapath, and the output register.

## Test plan
- Reset then idle: o_valid=0, o_result=0, o_ready=1. ADD 5+7 with i_ready=1 → o_result=12 one cycle later.
- SUB 0−1 → 0xFFFF_FFFF. SLT(−1,1)=1. SLTU(0xFFFF_FFFF,1)=0. Back-to-back with i_ready=1 → one result per cycle.
- SRA 0x8000_0000 by 4 → 0xF800_0000 at latency 5 with o_ready=0 for 4 cycles. SLL 1 by 0 → 1 at latency 1. SRL by 31 → latency 32.
- Backpressure: i_ready=0 for 3 cycles in DONE → o_result stable, o_ready=0. On release, a same-cycle new accept produces the next result one cycle later.
- Op code 12 → o_illegal=1, o_result=0. The next legal op clears o_illegal.
- i_reset mid-SHIFT (SLL by 20, reset at cycle 6) → next cycle o_valid=0, state IDLE, and no stale result ever appears. Repeat with ALU_SEQ_FAST_SHIFT_EN defined: all shifts at latency 1 with identical values.
